// File: rtl/bsg_manycore_link_out_arbiter.sv
// Output-link arbiter for the manycore bench network models.
// Up to nine input directions (P,W,E,N,S,RW,RE,RN,RS) share one outgoing link.
// The network configuration selects which directions are live.
// Each live input is granted round-robin into a single registered output slot.
// The arbiter also keeps three pieces of sticky or counting state:
// a starvation watchdog, an illegal-input flag and a count of delivered packets.

package bsg_manycore_network_pkg;
  typedef enum logic [2:0] {
    e_network_crossbar,
    e_network_mesh,
    e_network_half_ruche_x,
    e_network_full_ruche,
    e_network_max_val
  } bsg_manycore_network_cfg_e;
endpackage

module bsg_manycore_link_out_arbiter
  import bsg_manycore_network_pkg::*;
#(
  parameter bsg_manycore_network_cfg_e network_cfg_p = e_network_mesh,
  parameter int width_p        = 32,
  parameter int starve_limit_p = 64,
  parameter int num_in_p       = 9
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [num_in_p-1:0]         in_v_i,
  input  logic [num_in_p*width_p-1:0] in_data_i,
  output logic [num_in_p-1:0]         in_yumi_o,
  output logic                        out_v_o,
  output logic [width_p-1:0]          out_data_o,
  input  logic                        out_ready_i,
  output logic                        starve_o,
  output logic [3:0]                  starve_id_o,
  output logic                        err_o,
  output logic [15:0]                 pkt_count_o
);

  // Live directions per network flavour; slot order is P,W,E,N,S,RW,RE,RN,RS.
  function automatic logic [8:0] en_mask_f(bsg_manycore_network_cfg_e cfg);
    case (cfg)
      e_network_crossbar:     return 9'h001;
      e_network_mesh:         return 9'h01F;
      e_network_half_ruche_x: return 9'h07F;
      e_network_full_ruche:   return 9'h1FF;
      default:                return 9'h000;
    endcase
  endfunction

  if (num_in_p != 9) begin : g_bad_num_in
    $error("bsg_manycore_link_out_arbiter: num_in_p must be 9");
  end
  if (network_cfg_p != e_network_crossbar && network_cfg_p != e_network_mesh &&
      network_cfg_p != e_network_half_ruche_x && network_cfg_p != e_network_full_ruche) begin : g_bad_cfg
    $error("bsg_manycore_link_out_arbiter: unsupported network_cfg_p");
  end
  if (starve_limit_p < 1) begin : g_bad_limit
    $error("bsg_manycore_link_out_arbiter: starve_limit_p must be >= 1");
  end

  localparam logic [num_in_p-1:0] en_mask_lp = en_mask_f(network_cfg_p);
  localparam int wait_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [wait_w_lp-1:0] starve_lim_lp = wait_w_lp'(starve_limit_p);

  logic [3:0]          last_r;
  logic                accept;
  logic [num_in_p-1:0] req;
  logic [4:0]          rr_sum [num_in_p];
  logic [3:0]          rr_idx [num_in_p];
  logic                grant_v;
  logic [3:0]          grant_id;
  logic [width_p-1:0]  grant_data;

  logic [wait_w_lp-1:0] wait_r [num_in_p];
  logic [wait_w_lp-1:0] wait_n [num_in_p];
  logic                 starve_hit;
  logic [3:0]           starve_idx;

  // The slot can take a new packet if it is empty or is being drained this cycle.
  assign accept = ~out_v_o | out_ready_i;
  assign req    = in_v_i & en_mask_lp;

  // Build the round-robin search order, starting one slot past the last winner.
  always_comb begin
    for (int k = 0; k < num_in_p; k++) begin
      rr_sum[k] = {1'b0, last_r} + 5'(k + 1);
      rr_idx[k] = (rr_sum[k] >= 5'(num_in_p)) ? 4'(rr_sum[k] - 5'(num_in_p)) : rr_sum[k][3:0];
    end
  end

  // Grant the first requesting live input in search order when the slot can accept.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (!grant_v && req[rr_idx[k]]) begin
        grant_v  = 1'b1;
        grant_id = rr_idx[k];
      end
    end
    if (reset_i || !accept) begin
      grant_v = 1'b0;
    end
  end

  // Tell the granted input its packet is consumed.
  always_comb begin
    in_yumi_o = '0;
    if (grant_v) begin
      in_yumi_o[grant_id] = 1'b1;
    end
  end

  assign grant_data = in_data_i[grant_id*width_p +: width_p];

  // Output slot: load on a grant, empty when drained with no replacement.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_o    <= 1'b0;
      out_data_o <= '0;
      last_r     <= 4'd8;
    end else if (grant_v) begin
      out_v_o    <= 1'b1;
      out_data_o <= grant_data;
      last_r     <= grant_id;
    end else if (out_ready_i) begin
      out_v_o    <= 1'b0;
    end
  end

  // Wait counters restart whenever an input is idle or served and saturate at the limit.
  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      if (!en_mask_lp[i] || !in_v_i[i] || in_yumi_o[i]) begin
        wait_n[i] = '0;
      end else if (wait_r[i] != starve_lim_lp) begin
        wait_n[i] = wait_r[i] + wait_w_lp'(1);
      end else begin
        wait_n[i] = wait_r[i];
      end
    end
  end

  // Find the lowest live input whose wait count hits the limit; the scan runs downward so the lowest index wins.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = num_in_p - 1; i >= 0; i--) begin
      if (en_mask_lp[i] && wait_n[i] == starve_lim_lp) begin
        starve_hit = 1'b1;
        starve_idx = 4'(i);
      end
    end
  end

  // Update the watchdog, the sticky flags and the delivered-packet counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_in_p; i++) begin
        wait_r[i] <= '0;
      end
      starve_o    <= 1'b0;
      starve_id_o <= '0;
      err_o       <= 1'b0;
      pkt_count_o <= '0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        wait_r[i] <= wait_n[i];
      end
      if (!starve_o && starve_hit) begin
        starve_o    <= 1'b1;
        starve_id_o <= starve_idx;
      end
      if (|(in_v_i & ~en_mask_lp)) begin
        err_o <= 1'b1;
      end
      if (out_v_o && out_ready_i) begin
        pkt_count_o <= pkt_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bsg_manycore_link_out_arbiter.sv
// Bench for the output-link arbiter: a mesh instance (starve limit 4) and a full-ruche
// instance (starve limit 64) run side by side against a behavioural reference model.
module tb_bsg_manycore_link_out_arbiter;
  import bsg_manycore_network_pkg::*;

  localparam int w_lp = 32;
  localparam logic [8:0] mesh_mask_lp  = 9'h01F;
  localparam logic [8:0] ruche_mask_lp = 9'h1FF;
  localparam int mesh_lim_lp  = 4;
  localparam int ruche_lim_lp = 64;

  typedef struct packed {
    logic            out_v;
    logic [31:0]     out_data;
    logic [3:0]      last;
    logic [8:0][7:0] wc;
    logic            starve;
    logic [3:0]      sid;
    logic            err;
    logic [15:0]     cnt;
  } mstate_t;

  logic clk, reset;
  logic [8:0] m_v, r_v, m_yumi, r_yumi;
  logic [9*w_lp-1:0] m_d, r_d;
  logic m_ov, r_ov, m_rdy, r_rdy, m_st, r_st, m_err, r_err;
  logic [w_lp-1:0] m_od, r_od;
  logic [3:0] m_sid, r_sid;
  logic [15:0] m_cnt, r_cnt;

  mstate_t ms, rs;
  int total, bad;

  bsg_manycore_link_out_arbiter #(
    .network_cfg_p(e_network_mesh), .width_p(w_lp), .starve_limit_p(mesh_lim_lp), .num_in_p(9)
  ) u_mesh (
    .clk_i(clk), .reset_i(reset), .in_v_i(m_v), .in_data_i(m_d), .in_yumi_o(m_yumi),
    .out_v_o(m_ov), .out_data_o(m_od), .out_ready_i(m_rdy), .starve_o(m_st),
    .starve_id_o(m_sid), .err_o(m_err), .pkt_count_o(m_cnt)
  );

  bsg_manycore_link_out_arbiter #(
    .network_cfg_p(e_network_full_ruche), .width_p(w_lp), .starve_limit_p(ruche_lim_lp), .num_in_p(9)
  ) u_ruche (
    .clk_i(clk), .reset_i(reset), .in_v_i(r_v), .in_data_i(r_d), .in_yumi_o(r_yumi),
    .out_v_o(r_ov), .out_data_o(r_od), .out_ready_i(r_rdy), .starve_o(r_st),
    .starve_id_o(r_sid), .err_o(r_err), .pkt_count_o(r_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mstate_t reset_state();
    mstate_t n;
    n = '0;
    n.last = 4'd8;
    return n;
  endfunction

  // Winner this cycle, or -1: round-robin from one past the last winner, only if the slot can accept.
  function automatic int grant_of(mstate_t s, logic [8:0] mask, logic [8:0] v, logic rdy, logic rst);
    if (rst) return -1;
    if (s.out_v && !rdy) return -1;
    for (int k = 1; k <= 9; k++) begin
      int j;
      j = (int'(s.last) + k) % 9;
      if (v[j] && mask[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [8:0] yumi_of(int g);
    logic [8:0] y;
    y = '0;
    if (g >= 0) y[g] = 1'b1;
    return y;
  endfunction

  function automatic mstate_t step(mstate_t s, logic [8:0] mask, int limit, logic [8:0] v,
                                   logic [9*w_lp-1:0] d, logic rdy, logic rst);
    mstate_t n;
    int g;
    bit found;
    if (rst) return reset_state();
    n = s;
    g = grant_of(s, mask, v, rdy, rst);
    if (g >= 0) begin
      n.out_v = 1'b1;
      n.out_data = d[g*w_lp +: w_lp];
      n.last = 4'(g);
    end else if (s.out_v && rdy) begin
      n.out_v = 1'b0;
    end
    if (s.out_v && rdy) n.cnt = s.cnt + 16'd1;
    if ((v & ~mask) != 9'h0) n.err = 1'b1;
    found = 0;
    for (int i = 0; i < 9; i++) begin
      if (!mask[i] || !v[i] || g == i) n.wc[i] = 8'd0;
      else if (int'(s.wc[i]) < limit) n.wc[i] = s.wc[i] + 8'd1;
      if (mask[i] && int'(n.wc[i]) == limit && !s.starve && !found) begin
        n.starve = 1'b1;
        n.sid = 4'(i);
        found = 1;
      end
    end
    return n;
  endfunction

  task automatic cycle(input logic rst, input logic [8:0] vm, input logic [8:0] vr,
                       input logic rm, input logic rr);
    int gm, gr;
    @(negedge clk);
    reset = rst; m_v = vm; r_v = vr; m_rdy = rm; r_rdy = rr;
    for (int i = 0; i < 9; i++) begin
      m_d[i*w_lp +: w_lp] = $urandom;
      r_d[i*w_lp +: w_lp] = $urandom;
    end
    #1;
    gm = grant_of(ms, mesh_mask_lp, vm, rm, rst);
    gr = grant_of(rs, ruche_mask_lp, vr, rr, rst);
    check("m_yumi", m_yumi, yumi_of(gm));
    check("m_out_v", m_ov, ms.out_v);
    check("m_out_data", m_od, ms.out_data);
    check("m_starve", m_st, ms.starve);
    check("m_starve_id", m_sid, ms.sid);
    check("m_err", m_err, ms.err);
    check("m_pkt_count", m_cnt, ms.cnt);
    check("r_yumi", r_yumi, yumi_of(gr));
    check("r_out_v", r_ov, rs.out_v);
    check("r_out_data", r_od, rs.out_data);
    check("r_starve", r_st, rs.starve);
    check("r_starve_id", r_sid, rs.sid);
    check("r_err", r_err, rs.err);
    check("r_pkt_count", r_cnt, rs.cnt);
    ms = step(ms, mesh_mask_lp, mesh_lim_lp, vm, m_d, rm, rst);
    rs = step(rs, ruche_mask_lp, ruche_lim_lp, vr, r_d, rr, rst);
    @(posedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; m_v = '0; r_v = '0; m_rdy = 1'b0; r_rdy = 1'b0; m_d = '0; r_d = '0;
    ms = reset_state(); rs = reset_state();

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // Mesh: all five inputs valid, ready high, ten cycles.
    for (int c = 0; c < 10; c++) cycle(0, 9'h01F, 9'h000, 1, 1);
    #1;
    check("t1_pkt_count", m_cnt, 16'd9);

    // Mesh: disabled input 5 raised for one cycle.
    cycle(1, 0, 0, 1, 1);
    cycle(0, 9'h020, 9'h000, 1, 1);
    for (int c = 0; c < 3; c++) cycle(0, 9'h000, 9'h000, 1, 1);
    #1;
    check("t2_err", m_err, 1'b1);
    check("t2_out_v", m_ov, 1'b0);

    // Full ruche: inputs 0 and 8 valid right after reset.
    cycle(1, 0, 0, 1, 1);
    for (int c = 0; c < 5; c++) cycle(0, 9'h000, 9'h101, 1, 1);

    // Mesh: backpressure for five cycles, then release.
    cycle(1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) cycle(0, 9'h003, 9'h000, 0, 0);
    for (int c = 0; c < 3; c++) cycle(0, 9'h003, 9'h000, 1, 1);

    // Mesh starvation: inputs 2 and 3 held valid, no drain.
    cycle(1, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++) cycle(0, 9'h00C, 9'h000, 0, 0);
    #1;
    check("t5_starve", m_st, 1'b1);
    check("t5_starve_id", m_sid, 4'd3);

    // Randomised traffic with occasional resets and disabled-input strays.
    cycle(1, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic rst;
      logic [8:0] vm, vr;
      rst = ($urandom_range(0, 199) == 0);
      vm = 9'($urandom);
      if ($urandom_range(0, 15) != 0) vm = vm & mesh_mask_lp;
      vr = 9'($urandom);
      cycle(rst, vm, vr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Counter wrap: 65536 deliveries from reset.
    cycle(1, 0, 0, 1, 1);
    for (int c = 0; c < 65537; c++) cycle(0, 9'h01F, 9'h1FF, 1, 1);
    #1;
    check("wrap_m_count", m_cnt, 16'h0000);
    check("wrap_r_count", r_cnt, 16'h0000);

    // Reset while a packet sits in the output slot.
    cycle(1, 9'h01F, 9'h1FF, 0, 0);
    #1;
    check("rst_m_out_v", m_ov, 1'b0);
    check("rst_m_out_data", m_od, 32'h0);
    check("rst_r_out_v", r_ov, 1'b0);
    check("rst_r_count", r_cnt, 16'h0);
    cycle(0, 9'h01F, 9'h1FF, 1, 1);
    cycle(0, 9'h01F, 9'h1FF, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
